// File: rtl/mips16_pkg.sv
// mips16_pkg: opcodes and controller state type
// shared by the multi-cycle core and its register file
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/mips16_regfile.sv
// mips16_regfile: 2 async read ports, 1 sync write port
// r0 always reads zero and ignores writes
module mips16_regfile
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  // register array, cleared by reset, r0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mips16_multicycle_core.sv
// mips16_multicycle_core: FETCH/DECODE/EXEC/MEM/WB controller
// sharing one req/ack memory port for fetch and data
module mips16_multicycle_core
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] alu_out,
  output logic              retire,
  output logic              halted,
  output logic              illegal_op
);

  localparam int RW = $clog2(NREGS);

  state_t state, state_nx;

  logic              run;
  logic              halt_done;
  logic [15:0]       ir;
  logic [3:0]        op;
  logic [RW-1:0]     fa, fs, fb, rb_sel;
  logic [DATA_W-1:0] opa, opb, mdr;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] alu_nx, wb_data, imm;
  logic [ADDR_W-1:0] npc, npc_nx;
  logic [ADDR_W-1:0] pc_inc, jtarget, off;
  logic              is_illegal, wr_en, rf_we;

  assign op = ir[15:12];
  assign fa = ir[8 +: RW];
  assign fs = ir[4 +: RW];
  assign fb = ir[0 +: RW];

  assign imm = {{(DATA_W-4){ir[3]}}, ir[3:0]};
  assign off = {{(ADDR_W-4){ir[3]}}, ir[3:0]};
  assign pc_inc = pc + ADDR_W'(1);

  if (ADDR_W <= 12) begin : g_jnarrow
    assign jtarget = ir[ADDR_W-1:0];
  end else begin : g_jwide
    assign jtarget = {{(ADDR_W-12){1'b0}}, ir[11:0]};
  end

  assign is_illegal = (op > OP_BEQ) && (op != OP_HALT);
  assign wr_en = op inside {OP_ADD, OP_SUB, OP_ADDI,
                            OP_LW, OP_XOR, OP_OR};

  // SW and BEQ need R[A] on the second port
  assign rb_sel = (op == OP_SW || op == OP_BEQ) ? fa : fb;
  assign rf_we = (state == ST_WB) && wr_en;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;
  assign mem_wdata = opb;

  mips16_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr_a(fs),
    .raddr_b(rb_sel),
    .rdata_a(rd_a),
    .rdata_b(rd_b),
    .we     (rf_we),
    .waddr  (fa),
    .wdata  (wb_data)
  );

  // ALU result and next pc, both resolved in EXEC
  always_comb begin
    alu_nx = '0;
    npc_nx = pc_inc;
    case (op)
      OP_ADD:  alu_nx = opa + opb;
      OP_SUB:  alu_nx = opa - opb;
      OP_ADDI,
      OP_LW,
      OP_SW:   alu_nx = opa + imm;
      OP_XOR:  alu_nx = opa ^ opb;
      OP_OR:   alu_nx = opa | opb;
      OP_JUMP: npc_nx = jtarget;
      OP_BEQ:  if (opa == opb) npc_nx = pc_inc + off;
      default: ;
    endcase
  end

  // controller state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nx;
  end

  // next state and memory port; run holds off requests during reset
  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    retire   = 1'b0;
    halted   = 1'b0;
    unique case (state)
      ST_FETCH: begin
        mem_req = run;
        if (run && mem_ack) state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_LW || op == OP_SW) state_nx = ST_MEM;
        else if (op == OP_HALT)         state_nx = ST_HALT;
        else                            state_nx = ST_WB;
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = alu_out[ADDR_W-1:0];
        if (mem_ack) state_nx = ST_WB;
      end
      ST_WB: begin
        retire   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        retire = ~halt_done;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  // datapath registers loaded per controller state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run        <= 1'b0;
      halt_done  <= 1'b0;
      ir         <= '0;
      opa        <= '0;
      opb        <= '0;
      mdr        <= '0;
      alu_out    <= '0;
      npc        <= '0;
      pc         <= '0;
      illegal_op <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_FETCH: if (run && mem_ack) ir <= mem_rdata[15:0];
        ST_DECODE: begin
          opa <= rd_a;
          opb <= rd_b;
        end
        ST_EXEC: begin
          alu_out <= alu_nx;
          npc     <= npc_nx;
          if (is_illegal) illegal_op <= 1'b1;
        end
        ST_MEM: if (mem_ack && op == OP_LW) mdr <= mem_rdata;
        ST_WB: pc <= npc;
        ST_HALT: halt_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_multicycle_core.sv
// tb_mips16_multicycle_core: ISA-level model feeds scoreboards
// checked by a memory responder and a retire monitor
module tb_mips16_multicycle_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, alu_out;
  logic        retire, halted, illegal_op;

  always #5 clk = ~clk;

  mips16_multicycle_core #(
    .DATA_W(16),
    .ADDR_W(8),
    .NREGS (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .pc        (pc),
    .alu_out   (alu_out),
    .retire    (retire),
    .halted    (halted),
    .illegal_op(illegal_op)
  );

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    bit          data;
  } mtx_t;

  typedef struct {
    logic [7:0]  pc;
    bit          chk_alu;
    logic [15:0] alu;
    int          base;
    bit          ill;
  } rtx_t;

  mtx_t        exp_mem[$];
  rtx_t        exp_ret[$];
  logic [15:0] mem [256];

  int checks = 0;
  int passed = 0;
  bit sb_on = 0;
  bit rnd_wait = 0;
  int fwait = 0;
  int dwait = 0;
  int nret_exp = 0;
  int ret_cnt = 0;
  int wait_acc = 0;
  bit m_ill = 0;

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // instruction-set model: walks the program, queues expectations
  task automatic model_run(input int n_instr);
    logic [15:0] mm [256];
    logic [15:0] r [16];
    logic [7:0]  p;
    bit          ill;
    mm = mem;
    for (int i = 0; i < 16; i++) r[i] = '0;
    p = 8'h00;
    ill = 0;
    nret_exp = 0;
    for (int k = 0; k < n_instr; k++) begin
      logic [15:0] ir, va, vs, vb, sum, res, wval;
      logic [3:0]  op, a, s, b;
      logic [7:0]  np;
      bit          wr;
      rtx_t        rt;
      ir = mm[p];
      op = ir[15:12]; a = ir[11:8]; s = ir[7:4]; b = ir[3:0];
      va = r[a]; vs = r[s]; vb = r[b];
      sum = vs + {{12{b[3]}}, b};
      np = p + 8'd1;
      wr = 0; res = '0; wval = '0;
      rt.chk_alu = 1; rt.base = 4;
      exp_mem.push_back(mtx_t'{we: 0, addr: p, wdata: 0, data: 0});
      case (op)
        4'h0: begin res = vs + vb; wr = 1; end
        4'h1: begin res = vs - vb; wr = 1; end
        4'h2: begin res = sum; wr = 1; end
        4'h3: begin
          res = sum; wr = 1; rt.base = 5;
          exp_mem.push_back(mtx_t'{we: 0, addr: sum[7:0], wdata: 0, data: 1});
        end
        4'h4: begin
          res = sum; rt.base = 5;
          exp_mem.push_back(mtx_t'{we: 1, addr: sum[7:0], wdata: va, data: 1});
        end
        4'h5: begin rt.chk_alu = 0; np = ir[7:0]; end
        4'h6: begin res = vs ^ vb; wr = 1; end
        4'h7: begin res = vs | vb; wr = 1; end
        4'h8: begin
          rt.chk_alu = 0;
          if (va == vs) np = p + 8'd1 + {{4{b[3]}}, b};
        end
        4'hF: rt.chk_alu = 0;
        default: begin rt.chk_alu = 0; ill = 1; end
      endcase
      wval = (op == 4'h3) ? mm[sum[7:0]] : res;
      if (op == 4'h4) mm[sum[7:0]] = va;
      if (wr && a != 4'h0) r[a] = wval;
      rt.pc = p; rt.alu = res; rt.ill = ill;
      exp_ret.push_back(rt);
      nret_exp++;
      if (op == 4'hF) break;
      p = np;
    end
    m_ill = ill;
  endtask

  // memory responder with wait states; checks each transaction
  initial begin
    bit          busy;
    int          left;
    logic        s_we;
    logic [7:0]  s_addr;
    logic [15:0] s_wd;
    mtx_t        e;
    busy = 0; left = 0;
    s_we = 0; s_addr = '0; s_wd = '0;
    mem_ack = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 0;
      if (rst) begin
        busy = 0;
        wait_acc = 0;
      end else if (mem_req) begin
        if (!busy) begin
          busy = 1;
          s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
          if (rnd_wait) left = $urandom_range(0, 2);
          else if (exp_mem.size() > 0 && exp_mem[0].data) left = dwait;
          else left = fwait;
        end else if (sb_on) begin
          check("req_stable", {mem_we, mem_addr, mem_wdata},
                {s_we, s_addr, s_wd});
        end
        if (left == 0) begin
          mem_ack = 1;
          mem_rdata = mem[mem_addr];
          busy = 0;
          if (sb_on) begin
            if (exp_mem.size() > 0) begin
              e = exp_mem.pop_front();
              check("mem_tx",
                    {mem_we, mem_addr, mem_we ? mem_wdata : 16'h0},
                    {e.we, e.addr, e.wdata});
            end else if (ret_cnt < nret_exp) begin
              checks++;
              $display("FAIL extra_mem_tx: got addr %0h expected none",
                       mem_addr);
            end
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
        end else begin
          left--;
          wait_acc++;
        end
      end else begin
        busy = 0;
      end
    end
  end

  // retire monitor: pc, result, sticky flag and cycle count
  initial begin
    bit   active;
    int   cyc;
    rtx_t r;
    active = 0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; cyc = 0; ret_cnt = 0;
      end else if (active || mem_req) begin
        active = 1;
        cyc++;
        if (retire) begin
          ret_cnt++;
          if (sb_on) begin
            if (exp_ret.size() > 0) begin
              r = exp_ret.pop_front();
              check("retire_pc", pc, r.pc);
              if (r.chk_alu) check("alu_out", alu_out, r.alu);
              check("illegal_op", illegal_op, r.ill);
              check("cycles", cyc, r.base + wait_acc);
            end else begin
              checks++;
              $display("FAIL extra_retire: got pc %0h expected none", pc);
            end
          end
          cyc = 0;
          wait_acc = 0;
        end
      end
    end
  end

  task automatic run_prog(input int n, input bit halts);
    int t;
    rst = 1; sb_on = 0;
    exp_mem.delete(); exp_ret.delete();
    repeat (2) @(negedge clk);
    model_run(n);
    sb_on = 1;
    rst = 0;
    t = 0;
    while (ret_cnt < nret_exp && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("retire_count", ret_cnt, nret_exp);
    if (halts) begin
      int reqs = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_req) reqs++;
      end
      check("halt_no_req", reqs, 0);
      check("halted", halted, 1);
      check("single_halt_retire", ret_cnt, nret_exp);
    end
    check("mem_q_empty", exp_mem.size(), 0);
    check("ret_q_empty", exp_ret.size(), 0);
    check("illegal_final", illegal_op, m_ill);
    sb_on = 0;
    rst = 1;
    @(negedge clk);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [12];
    ops = '{4'h0, 4'h1, 4'h2, 4'h2, 4'h3, 4'h4,
            4'h5, 4'h6, 4'h7, 4'h8, 4'h8, 4'hB};
    return {ops[$urandom_range(0, 11)], 12'($urandom)};
  endfunction

  initial begin
    rst = 1;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset values, first request, async reset of a pending fetch
    fwait = 4; dwait = 0; rnd_wait = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_illegal", illegal_op, 0);
    rst = 0;
    @(posedge clk); #1;
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_pc", pc, 0);

    // directed: ALU ops, branches, jumps, SW/LW with 3 waits, HALT
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h2105; mem[8'h01] = 16'h221F;
    mem[8'h02] = 16'h5010; mem[8'h10] = 16'h8113;
    mem[8'h14] = 16'h8123; mem[8'h15] = 16'h5030;
    mem[8'h30] = 16'h3308; mem[8'h31] = 16'h4312;
    mem[8'h32] = 16'h3412; mem[8'h33] = 16'h4406;
    mem[8'h34] = 16'h0011; mem[8'h35] = 16'h4005;
    mem[8'h36] = 16'h3509; mem[8'h37] = 16'h360A;
    mem[8'h38] = 16'h6756; mem[8'h39] = 16'h7856;
    mem[8'h3A] = 16'hA123; mem[8'h3B] = 16'h4700;
    mem[8'h3C] = 16'h4101; mem[8'h3D] = 16'hF000;
    mem[8'hF8] = 16'h1234; mem[8'hF9] = 16'hF0F0;
    mem[8'hFA] = 16'h0FF0;
    fwait = 0; dwait = 3; rnd_wait = 0;
    run_prog(100, 1);

    // directed: pc wrap from 0xFF to 0x00
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = 16'h8902; mem[8'h01] = 16'hF000;
    mem[8'h03] = 16'h50FF; mem[8'hFF] = 16'h2901;
    fwait = 1; dwait = 0;
    run_prog(20, 1);

    // random programs with random wait states
    rnd_wait = 1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = rand_instr();
      run_prog(150, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips16_multicycle_core.md
# mips16_multicycle_core

Parametrised multi-cycle successor to the single-cycle MIPS16 datapath. It uses the same 16-bit instruction encoding, and adds BEQ, HALT and illegal-opcode detection. Instruction fetch and data access share one external memory port with a req/ack handshake, so program and data memory live outside the core and may insert wait states. It sits as the CPU inside the tile top-level, and its debug outputs drive the pins.

## Interface
- DATA_W, 16: datapath/register width; must be ≥16 (instruction taken from mem_rdata[15:0]).
- ADDR_W, 8: word-address width of PC and memory port.
- NREGS, 16: register count, 8 or 16; register fields use the low $clog2(NREGS) bits.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_req  out  1  memory request; held until the ack cycle.
- mem_we  out  1  1 = write (SW), 0 = read (fetch/LW).
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.
- mem_ack  in  1  completes the request at this rising edge.
- pc  out  ADDR_W  current instruction address.
- alu_out  out  DATA_W  registered EXEC result.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped by HALT.
- illegal_op  out  1  sticky; an undefined opcode was executed.

## Operation
- Encoding: opcode [15:12], A [11:8], rs [7:4], B [3:0].
- imm = sign-extended B; j12 = [11:0].
- 0 ADD rd=A: rs+rt(B).
- 1 SUB: rs−rt.
- 2 ADDI: rd = rs+imm.
- 3 LW: rd = M[rs+imm].
- 4 SW: M[rs+imm] = R[A].
- 5 JUMP: pc = j12[ADDR_W-1:0].
- 6 XOR, 7 OR: register forms.
- 8 BEQ: if R[A]==R[rs], pc = pc+1+imm; else pc+1.
- F HALT.
- Other opcodes: executed as NOP, set illegal_op.
- r0 reads 0; writes to r0 are ignored.
- Arithmetic is modulo 2^DATA_W. Memory address is ALU result [ADDR_W-1:0]. PC wraps from 2^ADDR_W−1 to 0.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, addr=pc. On ack, latch IR and go to DECODE.
  - DECODE: read rs/rt into operand registers.
  - EXEC: compute ALU result into alu_out. Resolve the branch target. LW/SW go to MEM; HALT goes to HALT; all others go to WB.
  - MEM: request with addr=alu_out[ADDR_W-1:0]. For SW, mem_we=1 and wdata=R[A]. On ack: LW latches rdata; go to WB.
  - WB: register write (ALU ops, ADDI, LW); pc update; retire=1; go to FETCH.
  - HALT: halted=1, retire=1 on entry, no further mem_req. Leaves only by rst.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. Requests are never withdrawn before ack.

## Timing
- Reset values: all registers and pc = 0; state = FETCH.
- Reset values of outputs: mem_req asserted only from the first clk edge after rst falls. alu_out=0, retire=0, halted=0, illegal_op=0.
- rst asserted mid-operation (including an outstanding MEM/FETCH request): all outputs return to reset values immediately and asynchronously. A late ack after reset is ignored.
- With zero-wait memory (ack in the first req cycle), an ALU/JUMP/BEQ/illegal instruction takes 4 cycles and LW/SW take 5. Each wait cycle adds one.
- retire pulses in the WB cycle. The register write and new pc are visible in the following FETCH cycle.
- illegal_op sets in EXEC and clears only on rst.

## Structure
- Package mips16_pkg: opcode localparams (OP_ADD..OP_HALT) and the state enum type.
- Sub-module mips16_regfile (DATA_W, NREGS): 2 combinational read ports, 1 synchronous write port, async reset to 0, r0 hardwired to 0.
- Controller FSM and datapath stay in the core.

## Test plan
- Reset, then release → first cycle mem_req=1, addr 0x00. Assert rst at cycle 3 → mem_req=0 and pc=0 immediately.
- ADDI r1,r0,5; ADDI r2,r1,-1 (0x221F); zero-wait memory → alu_out=4, r2=4, retire every 4 cycles.
- SW then LW with 3-cycle ack delay: r3=0x1234, SW r3→M[rs+2], LW r4 from the same address → mem_req and addr stable through the wait, SW with mem_we=1, r4=0x1234, LW takes 8 cycles.
- BEQ r1,r1,+3 at pc 0x10 → next fetch 0x14. BEQ r1,r2 with r1≠r2 → 0x11. JUMP 0x00A → fetch 0x0A. JUMP at pc 0xFF with ADDI fallthrough → wrap to 0x00.
- Opcode 0xA → illegal_op=1, registers unchanged, pc+1. Then HALT 0xF000 → halted=1, one retire, no mem_req for 20 cycles.
- ADD r0,r1,r1 → r0 still reads 0. XOR/OR on 0xF0F0/0x0FF0 → 0xFF00 and 0xFFF0.
